irq_core_handshake: RTL and testbench
=====================================

Name: irq_core_handshake

Overview:
- Sits directly downstream of the interrupt service unit and consumes its 32-bit masked interrupt vector.
- Captures rising edges of each line into a pending register.
- Arbitrates the pending lines and presents one interrupt ID to the core with a req/ack handshake.
- Clears the serviced pending bit when the core acknowledges, and emits an ack pulse that upstream logic can use.

Parameters:
- NUM_IRQ, 32, number of interrupt lines; 2..32.
- ID_WIDTH, 5, width of the interrupt ID; must satisfy 2**ID_WIDTH >= NUM_IRQ.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous reset, active-high.
- irq_i  in  NUM_IRQ  masked interrupt lines from the service unit, level.
- enable_i  in  1  global interrupt enable from the core; when low, no new request is issued.
- irq_req_o  out  1  interrupt request to the core.
- irq_id_o  out  ID_WIDTH  ID of the requested interrupt; valid while irq_req_o is high.
- irq_ack_i  in  1  core acknowledge; sampled only while irq_req_o is high.
- irq_ack_o  out  1  one-cycle pulse, the cycle after an accepted ack.
- irq_ack_id_o  out  ID_WIDTH  ID of the acknowledged interrupt; valid with irq_ack_o.
- pending_o  out  NUM_IRQ  current pending vector, for status and debug.

Behaviour:
- Reset: all outputs are 0; irq_prev, pending and the FSM state clear asynchronously on HRESET high. The FSM state after reset is IDLE.
- Edge capture:
  - Register irq_prev <= irq_i each cycle.
  - A rise on line k sets pending[k] the following cycle.
  - A line held high does not re-set pending after it is cleared; a new low-to-high transition is required.
- Pending update: pending_next = (pending & ~clr_mask) | rise_mask.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if enable_i and |pending, latch sel_id from the priority encoder into irq_id_o and go to REQ. irq_req_o goes high in the same cycle the state becomes REQ.
  - REQ: irq_req_o = 1. irq_id_o stays stable even if a higher-priority line becomes pending or enable_i drops; the request is never withdrawn once issued. On irq_ack_i: clr_mask = onehot(irq_id_o), irq_ack_o pulses next cycle with irq_ack_id_o = irq_id_o, and the FSM goes to GAP.
  - GAP: irq_req_o = 0 for exactly one cycle so the core sees a deasserted request and the pending clear settles; then go to IDLE.
- Latency:
  - Edge on irq_i sampled at cycle n -> pending at n+1 -> irq_req_o at n+2 (from IDLE with enable_i high).
  - Minimum spacing between consecutive requests is 3 cycles (REQ, GAP, IDLE).
- Arbitration, fixed priority: the lowest index wins (line 0 is highest).
- irq_ack_i while not in REQ is ignored.
- Reset during REQ: the request is lost and pending is cleared; upstream must re-raise the line.
- irq_id_o holds its last value outside REQ; checkers ignore it when irq_req_o is low.
- Lines with index >= NUM_IRQ do not exist; the encoder never produces an out-of-range ID.

Optional Feature:
- Macro: IRQ_ROUND_ROBIN_EN.
- Defined:
  - Arbitration is round-robin. A last_id register (reset 0) is updated on each accepted ack.
  - The search starts at last_id+1 modulo NUM_IRQ and wraps; the first pending line found wins.
  - If only last_id is pending, it is selected.
- Undefined: fixed lowest-index priority as above, and no last_id register exists.

Decomposition:
- Shared package event_unit_pkg holds:
  - NUM_IRQ_DEFAULT = 32 and ID_WIDTH_DEFAULT = 5.
  - typedef enum logic [1:0] {IDLE, REQ, GAP} irq_hs_state_e.
  - The function onehot_to_mask(id).
- One sub-module, irq_prio_enc: combinational, inputs pending and start_idx, outputs sel_id and any_valid.
  - start_idx is tied to 0 when IRQ_ROUND_ROBIN_EN is undefined.

Test Plan:
- Reset: hold HRESET for 3 cycles with irq_i = 32'hFFFF_FFFF -> all outputs 0. After release, pending = FFFF_FFFF only if the lines rise after reset; lines held high across reset produce no capture.
- Single IRQ: pulse irq_i[7] for 1 cycle at cycle n with enable_i = 1 -> irq_req_o = 1 and irq_id_o = 7 at n+2. Ack at n+4 -> irq_ack_o pulse at n+5 with irq_ack_id_o = 7; pending_o = 0 and irq_req_o = 0 during GAP.
- Priority and stability: raise lines 12 and 3 together -> ID 3 is requested first. Raise line 0 while in REQ -> ID stays 3. After ack, the next request is ID 0, then ID 12.
- Set-wins collision: ack ID 5 in the same cycle irq_i[5] has a new rising edge -> pending_o[5] remains 1 and ID 5 is re-requested 3 cycles later.
- Enable gating: pending = 0x10 and enable_i = 0 for 10 cycles -> irq_req_o stays 0. Raise enable_i -> irq_req_o = 1 and irq_id_o = 4 one cycle later.
- With IRQ_ROUND_ROBIN_EN: keep lines 1, 2 and 30 pending and re-raise each after its ack -> grant order 1, 2, 30, 1, 2 (wrap-around after 30).

Source files
------------

// File: rtl/event_unit_pkg.sv
// rtl/event_unit_pkg.sv - shared types and helpers for the interrupt handshake block
package event_unit_pkg;

  localparam int NUM_IRQ_DEFAULT  = 32;
  localparam int ID_WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_hs_state_e;

  function automatic logic [NUM_IRQ_DEFAULT-1:0] onehot_to_mask(input logic [ID_WIDTH_DEFAULT-1:0] id);
    logic [NUM_IRQ_DEFAULT-1:0] mask;
    mask     = '0;
    mask[id] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - picks the first pending line, searching upward from start_idx with wrap
module irq_prio_enc
  import event_unit_pkg::*;
#(
  parameter int NUM_IRQ  = NUM_IRQ_DEFAULT,
  parameter int ID_WIDTH = ID_WIDTH_DEFAULT
) (
  input  logic [NUM_IRQ-1:0]  pending,
  input  logic [ID_WIDTH-1:0] start_idx,
  output logic [ID_WIDTH-1:0] sel_id,
  output logic                any_valid
);

  logic [ID_WIDTH-1:0] idx;

  // Walk from the farthest offset down so the nearest pending line overwrites last.
  always_comb begin
    sel_id    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx = ID_WIDTH'((32'(start_idx) + 32'(i)) % NUM_IRQ);
      if (pending[idx]) begin
        sel_id    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_core_handshake.sv
// rtl/irq_core_handshake.sv - edge-captured pending interrupts presented to the core via req/ack
// Optional round-robin arbitration is enabled with IRQ_ROUND_ROBIN_EN.
module irq_core_handshake
  import event_unit_pkg::*;
#(
  parameter int NUM_IRQ  = NUM_IRQ_DEFAULT,
  parameter int ID_WIDTH = ID_WIDTH_DEFAULT
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic                enable_i,
  output logic                irq_req_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  input  logic                irq_ack_i,
  output logic                irq_ack_o,
  output logic [ID_WIDTH-1:0] irq_ack_id_o,
  output logic [NUM_IRQ-1:0]  pending_o
);

  irq_hs_state_e state, next_state;

  logic [NUM_IRQ-1:0]         irq_prev;
  logic [NUM_IRQ-1:0]         pending;
  logic [NUM_IRQ-1:0]         rise_mask;
  logic [NUM_IRQ-1:0]         clr_mask;
  logic [NUM_IRQ_DEFAULT-1:0] id_mask;
  logic                       armed;
  logic                       ack_accept;
  logic                       load_id;
  logic [ID_WIDTH-1:0]        sel_id;
  logic [ID_WIDTH-1:0]        start_idx;
  logic                       any_valid;

  // irq_prev is meaningless in the first cycle after reset, so lines already
  // high across reset are absorbed rather than captured.
  assign rise_mask  = armed ? (irq_i & ~irq_prev) : '0;
  assign ack_accept = (state == REQ) && irq_ack_i;
  assign id_mask    = onehot_to_mask(ID_WIDTH_DEFAULT'(irq_id_o));
  assign clr_mask   = ack_accept ? id_mask[NUM_IRQ-1:0] : '0;
  assign irq_req_o  = (state == REQ);
  assign pending_o  = pending;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] last_id;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      last_id <= '0;
    end else if (ack_accept) begin
      last_id <= irq_id_o;
    end
  end

  assign start_idx = (last_id == ID_WIDTH'(NUM_IRQ - 1)) ? '0 : last_id + 1'b1;
`else
  assign start_idx = '0;
`endif

  irq_prio_enc #(
    .NUM_IRQ  (NUM_IRQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio_enc (
    .pending   (pending),
    .start_idx (start_idx),
    .sel_id    (sel_id),
    .any_valid (any_valid)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state        <= IDLE;
      irq_prev     <= '0;
      pending      <= '0;
      armed        <= 1'b0;
      irq_id_o     <= '0;
      irq_ack_o    <= 1'b0;
      irq_ack_id_o <= '0;
    end else begin
      state        <= next_state;
      irq_prev     <= irq_i;
      armed        <= 1'b1;
      // Set wins over clear when both hit the same bit.
      pending      <= (pending & ~clr_mask) | rise_mask;
      irq_ack_o    <= ack_accept;
      if (load_id) begin
        irq_id_o <= sel_id;
      end
      if (ack_accept) begin
        irq_ack_id_o <= irq_id_o;
      end
    end
  end

  always_comb begin
    next_state = state;
    load_id    = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i && any_valid) begin
          next_state = REQ;
          load_id    = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          next_state = GAP;
        end
      end
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_core_handshake.sv
// tb/tb_irq_core_handshake.sv - directed self-checking bench for irq_core_handshake
module tb_irq_core_handshake;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] irq_i;
  logic        enable_i;
  logic        irq_req_o;
  logic [4:0]  irq_id_o;
  logic        irq_ack_i;
  logic        irq_ack_o;
  logic [4:0]  irq_ack_id_o;
  logic [31:0] pending_o;

  int vectors    = 0;
  int miscompares = 0;

  irq_core_handshake #(
    .NUM_IRQ  (32),
    .ID_WIDTH (5)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .irq_i        (irq_i),
    .enable_i     (enable_i),
    .irq_req_o    (irq_req_o),
    .irq_id_o     (irq_id_o),
    .irq_ack_i    (irq_ack_i),
    .irq_ack_o    (irq_ack_o),
    .irq_ack_id_o (irq_ack_id_o),
    .pending_o    (pending_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

`ifdef IRQ_ROUND_ROBIN_EN
  task automatic grant(input logic [4:0] exp_id);
    int n;
    logic [31:0] line;
    n = 0;
    while (!irq_req_o && n < 10) begin
      tick();
      n++;
    end
    check("rr_req", {31'd0, irq_req_o}, 32'd1);
    check("rr_id", {27'd0, irq_id_o}, {27'd0, exp_id});
    line = 32'd1 << exp_id;
    irq_ack_i = 1'b1;
    irq_i     = line;
    tick();
    irq_ack_i = 1'b0;
    irq_i     = '0;
    tick();
  endtask
`endif

  initial begin
    HRESET    = 1'b1;
    irq_i     = 32'hFFFF_FFFF;
    enable_i  = 1'b0;
    irq_ack_i = 1'b0;

    // Reset with every line high
    repeat (3) tick();
    check("rst_req", {31'd0, irq_req_o}, 32'd0);
    check("rst_id", {27'd0, irq_id_o}, 32'd0);
    check("rst_ack", {31'd0, irq_ack_o}, 32'd0);
    check("rst_ack_id", {27'd0, irq_ack_id_o}, 32'd0);
    check("rst_pending", pending_o, 32'd0);
    HRESET = 1'b0;
    tick();
    tick();
    check("held_no_capture", pending_o, 32'd0);
    irq_i = '0;
    tick();
    irq_i = 32'hFFFF_FFFF;
    tick();
    check("all_rise_capture", pending_o, 32'hFFFF_FFFF);
    check("all_rise_disabled_req", {31'd0, irq_req_o}, 32'd0);
    HRESET = 1'b1;
    #1;
    check("async_rst_pending", pending_o, 32'd0);
    tick();
    HRESET   = 1'b0;
    irq_i    = '0;
    enable_i = 1'b1;
    tick();

    // Single interrupt on line 7
    irq_i = 32'h0000_0080;
    tick();
    check("single_pending", pending_o, 32'h0000_0080);
    check("single_req_early", {31'd0, irq_req_o}, 32'd0);
    irq_i = '0;
    tick();
    check("single_req", {31'd0, irq_req_o}, 32'd1);
    check("single_id", {27'd0, irq_id_o}, 32'd7);
    tick();
    check("single_req_hold", {31'd0, irq_req_o}, 32'd1);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    check("single_ack_pulse", {31'd0, irq_ack_o}, 32'd1);
    check("single_ack_id", {27'd0, irq_ack_id_o}, 32'd7);
    check("single_gap_pending", pending_o, 32'd0);
    check("single_gap_req", {31'd0, irq_req_o}, 32'd0);
    tick();
    check("single_ack_one_cycle", {31'd0, irq_ack_o}, 32'd0);

    // Ack outside REQ is ignored
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    check("stray_ack", {31'd0, irq_ack_o}, 32'd0);
    check("stray_ack_req", {31'd0, irq_req_o}, 32'd0);

    // Reset while a request is outstanding
    irq_i = 32'h0000_0004;
    tick();
    irq_i = '0;
    tick();
    check("rst_req_pre", {27'd0, irq_id_o}, 32'd2);
    HRESET = 1'b1;
    #1;
    check("rst_in_req_req", {31'd0, irq_req_o}, 32'd0);
    check("rst_in_req_pending", pending_o, 32'd0);
    tick();
    HRESET = 1'b0;
    tick();

`ifndef IRQ_ROUND_ROBIN_EN
    // Fixed priority and ID stability
    irq_i = 32'h0000_1008;
    tick();
    check("prio_pending", pending_o, 32'h0000_1008);
    tick();
    check("prio_first_id", {27'd0, irq_id_o}, 32'd3);
    irq_i = 32'h0000_1009;
    tick();
    check("prio_stable_req", {31'd0, irq_req_o}, 32'd1);
    check("prio_stable_id", {27'd0, irq_id_o}, 32'd3);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    irq_i     = '0;
    check("prio_ack_id3", {27'd0, irq_ack_id_o}, 32'd3);
    check("prio_after_ack3", pending_o, 32'h0000_1001);
    tick();
    tick();
    check("prio_second_id", {27'd0, irq_id_o}, 32'd0);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    tick();
    tick();
    check("prio_third_id", {27'd0, irq_id_o}, 32'd12);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    check("prio_drained", pending_o, 32'd0);
    tick();
`endif

    // Set wins when rise and ack clear coincide
    irq_i = 32'h0000_0020;
    tick();
    irq_i = '0;
    tick();
    check("collide_id", {27'd0, irq_id_o}, 32'd5);
    irq_ack_i = 1'b1;
    irq_i     = 32'h0000_0020;
    tick();
    irq_ack_i = 1'b0;
    irq_i     = '0;
    check("collide_ack", {31'd0, irq_ack_o}, 32'd1);
    check("collide_pending", pending_o, 32'h0000_0020);
    tick();
    check("collide_idle_req", {31'd0, irq_req_o}, 32'd0);
    tick();
    check("collide_rereq", {31'd0, irq_req_o}, 32'd1);
    check("collide_rereq_id", {27'd0, irq_id_o}, 32'd5);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    tick();

    // Enable gating
    enable_i = 1'b0;
    irq_i    = 32'h0000_0010;
    tick();
    irq_i = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_req_low", {31'd0, irq_req_o}, 32'd0);
    end
    check("gate_pending", pending_o, 32'h0000_0010);
    enable_i = 1'b1;
    tick();
    check("gate_req", {31'd0, irq_req_o}, 32'd1);
    check("gate_id", {27'd0, irq_id_o}, 32'd4);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    tick();

`ifdef IRQ_ROUND_ROBIN_EN
    // Round-robin grant order with wrap after line 30
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    tick();
    irq_i = 32'h4000_0006;
    tick();
    irq_i = '0;
    grant(5'd1);
    grant(5'd2);
    grant(5'd30);
    grant(5'd1);
    grant(5'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
